general_register_write_arbiter: RTL and testbench

- Shares the single write port of the general register file between two writeback requesters: requester 0 is execute and requester 1 is load/microcode.
- Each requester has a one-entry buffer. The buffers are arbitrated round-robin.
- The 8/16/32-bit register-name encoding (AL..BH, AX..DI, EAX..EDI) is converted into a physical register index plus byte enables, with data steered to the correct byte lanes.
- A per-register busy vector is exported so decode can stall on pending writes.

---
 rtl/general_register_write_arbiter_if.sv | 26 ++
 rtl/general_register_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_general_register_write_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/general_register_write_arbiter_if.sv
// Writeback request/response bundle between the two writeback requesters and
// the general register file write port.
interface general_register_write_arbiter_if;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][2:0]   req_index;
  logic [1:0][1:0]   req_bit_width;
  logic [1:0][31:0]  req_data;

  logic              rf_we;
  logic [2:0]        rf_index;
  logic [3:0]        rf_byte_enable;
  logic [31:0]       rf_wdata;
  logic [7:0]        busy;
  logic              illegal_width;

  modport master (
    output req_valid, req_index, req_bit_width, req_data,
    input  req_ready, rf_we, rf_index, rf_byte_enable, rf_wdata, busy, illegal_width
  );

  modport slave (
    input  req_valid, req_index, req_bit_width, req_data,
    output req_ready, rf_we, rf_index, rf_byte_enable, rf_wdata, busy, illegal_width
  );
endinterface

// File: rtl/general_register_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between execute and
// load/microcode, with x86 8/16/32-bit register name to byte-lane translation.
module general_register_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           hold,
  general_register_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    W8        = 2'b00,
    W16       = 2'b01,
    W32       = 2'b10,
    W_ILLEGAL = 2'b11
  } width_e;

  typedef struct packed {
    logic [2:0]            index;
    width_e                width;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [1:0]  full_q, full_d;
  entry_t      buf_q [2];
  entry_t      buf_d [2];
  logic        ptr_q, ptr_d;
  logic        out_valid_q, out_valid_d;
  logic [2:0]  out_index_q, out_index_d;
  logic [3:0]  out_be_q, out_be_d;
  logic [31:0] out_wdata_q, out_wdata_d;
  logic        illegal_q, illegal_d;

  logic [1:0]          grant;
  logic                winner;
  logic [1:0]          ready;
  logic [1:0]          accept;
  entry_t              sel;
  logic [NUM_REGS-1:0] busy_vec;

  // AH/CH/DH/BH (8-bit codes 4-7) live in byte 1 of registers 0-3.
  function automatic logic [2:0] phys_index(entry_t e);
    return (e.width == W8) ? {1'b0, e.index[1:0]} : e.index;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    unique case (full_q)
      2'b11:   winner = ptr_q;
      2'b10:   winner = 1'b1;
      default: winner = 1'b0;
    endcase
    if (!hold && (full_q != 2'b00)) grant[winner] = 1'b1;
    ready  = ~full_q | grant;
    accept = bus.req_valid & ready;
  end

  always_comb begin
    sel         = buf_q[winner];
    out_valid_d = |grant;
    out_index_d = '0;
    out_be_d    = '0;
    out_wdata_d = '0;
    if (|grant) begin
      out_index_d = phys_index(sel);
      unique case (sel.width)
        W8: begin
          if (sel.index[2]) begin
            out_be_d    = 4'b0010;
            out_wdata_d = {16'h0, sel.data[7:0], 8'h0};
          end else begin
            out_be_d    = 4'b0001;
            out_wdata_d = {24'h0, sel.data[7:0]};
          end
        end
        W16: begin
          out_be_d    = 4'b0011;
          out_wdata_d = {16'h0, sel.data[15:0]};
        end
        default: begin
          out_be_d    = 4'b1111;
          out_wdata_d = sel.data;
        end
      endcase
    end
  end

  // A granted buffer empties and may be refilled by the same cycle's request.
  always_comb begin
    full_d    = full_q;
    buf_d     = buf_q;
    illegal_d = illegal_q;
    ptr_d     = (|grant) ? ~winner : ptr_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) full_d[i] = 1'b0;
      if (accept[i]) begin
        full_d[i]       = 1'b1;
        buf_d[i].index  = bus.req_index[i];
        buf_d[i].data   = bus.req_data[i];
        if (bus.req_bit_width[i] == W_ILLEGAL) begin
          buf_d[i].width = W32;
          illegal_d      = 1'b1;
        end else begin
          buf_d[i].width = width_e'(bus.req_bit_width[i]);
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q      <= '0;
      ptr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_be_q    <= '0;
      out_wdata_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      full_q      <= full_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_be_q    <= out_be_d;
      out_wdata_q <= out_wdata_d;
      illegal_q   <= illegal_d;
    end
  end

  // NOTE: buffer payload is left unreset; it is only ever read while its full bit is set.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < 2; i++) begin
      if (full_q[i]) busy_vec[phys_index(buf_q[i])] = 1'b1;
    end
    if (out_valid_q) busy_vec[out_index_q] = 1'b1;
  end

  assign bus.req_ready      = ready;
  assign bus.rf_we          = out_valid_q;
  assign bus.rf_index       = out_index_q;
  assign bus.rf_byte_enable = out_be_q;
  assign bus.rf_wdata       = out_wdata_q;
  assign bus.busy           = busy_vec;
  assign bus.illegal_width  = illegal_q;

endmodule

// File: tb/tb_general_register_write_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a transaction-level model.
module tb_general_register_write_arbiter;

  localparam int MAX_WAIT = 200;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic hold  = 1'b0;

  always #5 clock = ~clock;

  general_register_write_arbiter_if bus ();

  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic [2:0]  idx0 = '0, idx1 = '0;
  logic [1:0]  w0 = '0, w1 = '0;
  logic [31:0] d0 = '0, d1 = '0;

  assign bus.req_valid     = {valid1, valid0};
  assign bus.req_index     = {idx1, idx0};
  assign bus.req_bit_width = {w1, w0};
  assign bus.req_data      = {d1, d0};

  general_register_write_arbiter dut (
    .clock (clock),
    .reset (reset),
    .hold  (hold),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct { bit [2:0] index; bit [1:0] width; bit [31:0] data; } req_t;
  typedef struct { bit [2:0] index; bit [3:0] be; bit [31:0] wdata; } wr_t;
  typedef struct { int cyc; wr_t w; } log_t;

  bit   m_has [2];
  req_t m_ent [2];
  int   m_ptr;
  bit   m_out_v;
  wr_t  m_out;
  bit   m_illegal;
  log_t wr_log [$];
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic wr_t translate(req_t r);
    wr_t w;
    int lane;
    bit [31:0] val;
    lane = 0;
    if (r.width == 2'd0) begin
      lane    = (r.index >= 3'd4) ? 1 : 0;
      w.index = (r.index >= 3'd4) ? r.index - 3'd4 : r.index;
      w.be    = 4'(1 << lane);
      val     = r.data & 32'hFF;
    end else if (r.width == 2'd1) begin
      w.index = r.index;
      w.be    = 4'b0011;
      val     = r.data & 32'hFFFF;
    end else begin
      w.index = r.index;
      w.be    = 4'hF;
      val     = r.data;
    end
    w.wdata = val << (8 * lane);
    return w;
  endfunction

  function automatic int model_winner();
    if (hold) return -1;
    if (m_has[0] && m_has[1]) return m_ptr;
    if (m_has[0]) return 0;
    if (m_has[1]) return 1;
    return -1;
  endfunction

  function automatic bit [7:0] model_busy();
    bit [7:0] b;
    wr_t t;
    b = '0;
    for (int i = 0; i < 2; i++) begin
      if (m_has[i]) begin
        t = translate(m_ent[i]);
        b[t.index] = 1'b1;
      end
    end
    if (m_out_v) b[m_out.index] = 1'b1;
    return b;
  endfunction

  initial begin : model_proc
    bit       model_ok;
    int       win;
    bit [1:0] exp_ready;
    bit [1:0] vin;
    req_t     r;
    log_t     e;
    model_ok = 1'b0;
    forever begin
      @(negedge clock);
      win          = model_winner();
      exp_ready[0] = !m_has[0] || (win == 0);
      exp_ready[1] = !m_has[1] || (win == 1);
      if (model_ok) begin
        check("rf_we", 32'(bus.rf_we), 32'(m_out_v));
        if (m_out_v) begin
          check("rf_index", 32'(bus.rf_index), 32'(m_out.index));
          check("rf_byte_enable", 32'(bus.rf_byte_enable), 32'(m_out.be));
          check("rf_wdata", bus.rf_wdata, m_out.wdata);
        end
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("busy", 32'(bus.busy), 32'(model_busy()));
        check("illegal_width", 32'(bus.illegal_width), 32'(m_illegal));
      end
      if (bus.rf_we === 1'b1) begin
        e.cyc     = cyc;
        e.w.index = bus.rf_index;
        e.w.be    = bus.rf_byte_enable;
        e.w.wdata = bus.rf_wdata;
        wr_log.push_back(e);
      end
      // advance the model across the coming clock edge
      if (reset) begin
        m_has[0]  = 1'b0;
        m_has[1]  = 1'b0;
        m_ptr     = 0;
        m_out_v   = 1'b0;
        m_illegal = 1'b0;
        model_ok  = 1'b1;
      end else if (model_ok) begin
        if (win >= 0) begin
          m_out      = translate(m_ent[win]);
          m_out_v    = 1'b1;
          m_has[win] = 1'b0;
          m_ptr      = 1 - win;
        end else begin
          m_out_v = 1'b0;
        end
        vin = {valid1, valid0};
        for (int i = 0; i < 2; i++) begin
          if (vin[i] && exp_ready[i]) begin
            r.index  = (i == 0) ? idx0 : idx1;
            r.width  = (i == 0) ? w0 : w1;
            r.data   = (i == 0) ? d0 : d1;
            m_ent[i] = r;
            m_has[i] = 1'b1;
            if (r.width == 2'd3) m_illegal = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int i, input logic v, input logic [2:0] idx,
                       input logic [1:0] w, input logic [31:0] d);
    if (i == 0) begin
      valid0 = v; idx0 = idx; w0 = w; d0 = d;
    end else begin
      valid1 = v; idx1 = idx; w1 = w; d1 = d;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after the cycle that accepted.
  task automatic issue(input int i, input logic [2:0] idx, input logic [1:0] w, input logic [31:0] d);
    int waited;
    bit got;
    waited = 0;
    got    = 1'b0;
    drive(i, 1'b1, idx, w, d);
    while (!got && waited < MAX_WAIT) begin
      @(negedge clock);
      got = bus.req_ready[i];
      @(posedge clock);
      #2;
      waited++;
    end
    check($sformatf("accept_r%0d", i), 32'(got), 32'd1);
    drive(i, 1'b0, idx, w, d);
  endtask

  task automatic check_log(input string name, input int pos, input logic [2:0] idx,
                           input logic [3:0] be, input logic [31:0] wdata);
    wr_t w;
    w = '{default: '0};
    if (pos < wr_log.size()) w = wr_log[pos].w;
    check({name, "_index"}, 32'(w.index), 32'(idx));
    check({name, "_be"}, 32'(w.be), 32'(be));
    check({name, "_wdata"}, w.wdata, wdata);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  bit done0 = 1'b0, done1 = 1'b0;

  initial begin : main
    int   base;
    req_t pin;
    wr_t  pw;

    repeat (2) @(posedge clock);
    #2 reset = 1'b0;

    @(negedge clock);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_rf_index", 32'(bus.rf_index), 32'd0);
    check("rst_rf_be", 32'(bus.rf_byte_enable), 32'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd3);
    check("rst_illegal", 32'(bus.illegal_width), 32'd0);
    @(posedge clock); #2;

    // model pins: byte-lane steering for BH and SI
    pin = '{3'd7, 2'd0, 32'hFFFF_FF5A};
    pw  = translate(pin);
    check("model_bh_wdata", pw.wdata, 32'h0000_5A00);
    check("model_bh_index", 32'(pw.index), 32'd3);
    pin = '{3'd6, 2'd1, 32'hABCD_1234};
    pw  = translate(pin);
    check("model_si_wdata", pw.wdata, 32'h0000_1234);

    // single 32-bit write: latency and busy window
    issue(0, 3'd3, 2'b10, 32'hDEAD_BEEF);
    @(negedge clock);
    check("t1_busy_c2", 32'(bus.busy[3]), 32'd1);
    check("t1_we_c2", 32'(bus.rf_we), 32'd0);
    @(negedge clock);
    check("t1_we_c3", 32'(bus.rf_we), 32'd1);
    check("t1_index", 32'(bus.rf_index), 32'd3);
    check("t1_be", 32'(bus.rf_byte_enable), 32'hF);
    check("t1_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    check("t1_busy_c3", 32'(bus.busy[3]), 32'd1);
    @(negedge clock);
    check("t1_busy_c4", 32'(bus.busy[3]), 32'd0);
    check("t1_we_c4", 32'(bus.rf_we), 32'd0);
    @(posedge clock); #2;

    // BH then SI from requester 1, back to back
    base = wr_log.size();
    issue(1, 3'd7, 2'b00, 32'h0000_005A);
    issue(1, 3'd6, 2'b01, 32'h0000_1234);
    wait_cycles(4);
    check("t2_count", 32'(wr_log.size()), 32'(base + 2));
    check_log("t2_bh", base, 3'd3, 4'b0010, 32'h0000_5A00);
    check_log("t2_si", base + 1, 3'd6, 4'b0011, 32'h0000_1234);
    if (wr_log.size() >= base + 2)
      check("t2_back_to_back", 32'(wr_log[base + 1].cyc - wr_log[base].cyc), 32'd1);

    // both requesters streaming: alternate grants, continuous writes
    base = wr_log.size();
    fork
      begin
        for (int k = 0; k < 6; k++) issue(0, 3'(k), 2'b10, 32'h1000_0000 + 32'(k));
      end
      begin
        for (int k = 0; k < 6; k++) issue(1, 3'(k), 2'b10, 32'h2000_0000 + 32'(k));
      end
    join
    wait_cycles(5);
    check("t3_count", 32'(wr_log.size()), 32'(base + 12));
    for (int k = 0; k < 12; k++) begin
      if (base + k < wr_log.size()) begin
        check($sformatf("t3_order_%0d", k), wr_log[base + k].w.wdata,
              ((k % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(k / 2));
        if (k > 0)
          check($sformatf("t3_gap_%0d", k), 32'(wr_log[base + k].cyc - wr_log[base + k - 1].cyc), 32'd1);
      end
    end

    // hold: one accept each, then stalled; release drains requester 0 first
    base = wr_log.size();
    hold = 1'b1;
    fork
      begin
        issue(0, 3'd1, 2'b10, 32'h0000_00A0);
        issue(0, 3'd2, 2'b10, 32'h0000_00B0);
      end
      begin
        issue(1, 3'd4, 2'b10, 32'h0000_00C0);
        issue(1, 3'd5, 2'b10, 32'h0000_00D0);
      end
      begin
        wait_cycles(1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          check("t4_hold_ready", 32'(bus.req_ready), 32'd0);
          check("t4_hold_we", 32'(bus.rf_we), 32'd0);
        end
        @(posedge clock); #2;
        hold = 1'b0;
      end
    join
    wait_cycles(6);
    check("t4_count", 32'(wr_log.size()), 32'(base + 4));
    check_log("t4_w0", base, 3'd1, 4'hF, 32'h0000_00A0);
    check_log("t4_w1", base + 1, 3'd4, 4'hF, 32'h0000_00C0);
    check_log("t4_w2", base + 2, 3'd2, 4'hF, 32'h0000_00B0);
    check_log("t4_w3", base + 3, 3'd5, 4'hF, 32'h0000_00D0);

    // illegal width written as 32-bit, flag sticky
    base = wr_log.size();
    issue(0, 3'd2, 2'b11, 32'hCAFE_F00D);
    wait_cycles(4);
    check_log("t5", base, 3'd2, 4'hF, 32'hCAFE_F00D);
    check("t5_illegal", 32'(bus.illegal_width), 32'd1);
    wait_cycles(5);
    check("t5_illegal_sticky", 32'(bus.illegal_width), 32'd1);

    // reset with both buffers full discards everything
    fork
      issue(0, 3'd0, 2'b10, 32'h0000_0011);
      issue(1, 3'd1, 2'b10, 32'h0000_0022);
    join
    reset = 1'b1;
    base  = wr_log.size();
    wait_cycles(1);
    reset = 1'b0;
    @(negedge clock);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_ready", 32'(bus.req_ready), 32'd3);
    check("t6_we", 32'(bus.rf_we), 32'd0);
    check("t6_illegal", 32'(bus.illegal_width), 32'd0);
    @(posedge clock); #2;
    wait_cycles(4);
    check("t6_no_writes", 32'(wr_log.size()), 32'(base));

    // randomized traffic with random hold, checked by the model each cycle
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          wait_cycles($urandom_range(0, 2));
          issue(0, 3'($urandom), ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), $urandom);
        end
        done0 = 1'b1;
      end
      begin
        for (int n = 0; n < 150; n++) begin
          wait_cycles($urandom_range(0, 2));
          issue(1, 3'($urandom), ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), $urandom);
        end
        done1 = 1'b1;
      end
      begin
        while (!(done0 && done1)) begin
          wait_cycles(1);
          hold = ($urandom_range(0, 4) == 0);
        end
        hold = 1'b0;
      end
    join
    wait_cycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
